// File: rtl/system_bus_pkg.sv
// Shared system-bus definitions: default bus widths and the arbitration mode enum.
// Imported by the arbiter, its interface and any bus master.
package system_bus_pkg;

  localparam int unsigned SB_ADDR_WIDTH = 30;
  localparam int unsigned SB_DATA_WIDTH = 32;

  typedef enum logic {
    ARB_FIXED       = 1'b0,
    ARB_ROUND_ROBIN = 1'b1
  } arb_mode_e;

  // Width of a master index; a lone master still needs one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/system_bus_arbiter_if.sv
// System-bus bundle carrying NUM_PORTS packed request channels and one shared read-data return.
// Instantiated once with NUM_PORTS=N on the master side and once with NUM_PORTS=1 on the slave side.
interface system_bus_arbiter_if
  import system_bus_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 1,
  parameter int unsigned ADDR_WIDTH = SB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = SB_DATA_WIDTH
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            read_req;
  logic [NUM_PORTS-1:0]            write_req;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] write_data;
  logic [NUM_PORTS*BE_WIDTH-1:0]   byte_enable;
  logic [NUM_PORTS-1:0]            ready;
  logic [DATA_WIDTH-1:0]           read_data;
  logic [NUM_PORTS-1:0]            read_data_valid;

  modport master (
    output read_req, write_req, addr, write_data, byte_enable,
    input  ready, read_data, read_data_valid
  );

  modport slave (
    input  read_req, write_req, addr, write_data, byte_enable,
    output ready, read_data, read_data_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count; holds the master IDs of outstanding reads.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [WIDTH-1:0]     mem_d [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full     = (count_q == CNT_WIDTH'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CNT_WIDTH'(push_ok) - CNT_WIDTH'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/system_bus_arbiter.sv
// N-master to 1-slave system-bus arbiter, fixed-priority or round-robin, zero-cycle grant.
// Outstanding read IDs are queued so each read return is steered back to its issuer.
module system_bus_arbiter
  import system_bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = SB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = SB_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ROUND_ROBIN     = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  system_bus_arbiter_if.slave  m_bus,
  system_bus_arbiter_if.master s_bus,
  output logic                 idle,
  output logic                 protocol_error
);

  localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
  localparam int unsigned ID_WIDTH  = id_width(NUM_MASTERS);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
  localparam arb_mode_e   ARB_MODE  = (ROUND_ROBIN != 0) ? ARB_ROUND_ROBIN : ARB_FIXED;

  logic [ID_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;
  logic                   protocol_error_q, protocol_error_d;
  logic [ID_WIDTH-1:0]    base_ptr;
  logic [NUM_MASTERS-1:0] req, rot_req, gnt_oh, rdv;
  logic [ID_WIDTH-1:0]    gnt_idx, head_id;
  logic                   gnt_vld, gnt_write, accept, push, pop;
  logic                   fifo_full, fifo_empty;
  logic [CNT_WIDTH-1:0]   fifo_count;
  logic [ADDR_WIDTH-1:0]  bus_addr;
  logic [DATA_WIDTH-1:0]  bus_wdata;
  logic [BE_WIDTH-1:0]    bus_be;

  assign req      = m_bus.read_req | m_bus.write_req;
  assign base_ptr = (ARB_MODE == ARB_ROUND_ROBIN) ? rr_ptr_q : '0;
  // Rotate so the search always starts at bit 0; the pointer is added back after.
  assign rot_req  = (req >> base_ptr) | (req << (NUM_MASTERS - 32'(base_ptr)));

  always_comb begin
    int unsigned sel;
    gnt_vld = 1'b0;
    sel     = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!gnt_vld && rot_req[i]) begin
        gnt_vld = 1'b1;
        sel     = 32'(base_ptr) + i;
      end
    end
    if (sel >= NUM_MASTERS) begin
      sel = sel - NUM_MASTERS;
    end
    gnt_vld = gnt_vld & reset_n;
    gnt_idx = ID_WIDTH'(sel);
  end

  always_comb begin
    gnt_oh    = '0;
    gnt_write = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      gnt_oh[j] = gnt_vld && (gnt_idx == ID_WIDTH'(j));
      if (gnt_oh[j]) begin
        gnt_write = gnt_write | m_bus.write_req[j];
        bus_addr  = bus_addr  | m_bus.addr[j*ADDR_WIDTH +: ADDR_WIDTH];
        bus_wdata = bus_wdata | m_bus.write_data[j*DATA_WIDTH +: DATA_WIDTH];
        bus_be    = bus_be    | m_bus.byte_enable[j*BE_WIDTH +: BE_WIDTH];
      end
    end
  end

  // A full ID queue blocks reads even when a return frees a slot this cycle.
  assign accept = gnt_vld & s_bus.ready[0] & (gnt_write | ~fifo_full);
  assign push   = accept & ~gnt_write;
  assign pop    = reset_n & s_bus.read_data_valid[0] & ~fifo_empty;

  sync_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (gnt_idx),
    .pop       (pop),
    .pop_data  (head_id),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    for (int unsigned j = 0; j < NUM_MASTERS; j++) begin
      rdv[j] = pop && (head_id == ID_WIDTH'(j));
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (ARB_MODE == ARB_ROUND_ROBIN)) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
    end
    protocol_error_d = protocol_error_q | (s_bus.read_data_valid[0] & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_ptr_q         <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      rr_ptr_q         <= rr_ptr_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign m_bus.ready           = gnt_oh & {NUM_MASTERS{accept}};
  assign m_bus.read_data       = s_bus.read_data;
  assign m_bus.read_data_valid = rdv;

  assign s_bus.addr        = bus_addr;
  assign s_bus.write_data  = bus_wdata;
  assign s_bus.byte_enable = bus_be;
  assign s_bus.read_req    = gnt_vld & ~gnt_write & ~fifo_full;
  assign s_bus.write_req   = gnt_vld & gnt_write;

  assign idle           = (fifo_count == '0) & ~|req;
  assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_system_bus_arbiter.sv
// Bench for system_bus_arbiter: a fixed-priority N=2 instance and a round-robin N=3,
// MAX_OUTSTANDING=2 instance, directed scenarios plus random traffic against a queue model.
module tb_system_bus_arbiter;
  import system_bus_pkg::*;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;
  localparam int NF   = 2;
  localparam int NR   = 3;
  localparam int MAXR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  system_bus_arbiter_if #(.NUM_PORTS(NF), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fx_m ();
  system_bus_arbiter_if #(.NUM_PORTS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fx_s ();
  system_bus_arbiter_if #(.NUM_PORTS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rr_m ();
  system_bus_arbiter_if #(.NUM_PORTS(1),  .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rr_s ();

  logic idle_fx, perr_fx, idle_rr, perr_rr;

  system_bus_arbiter #(
    .NUM_MASTERS(NF), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4), .ROUND_ROBIN(0)
  ) dut_fx (
    .clk(clk), .reset_n(rst_n), .m_bus(fx_m), .s_bus(fx_s),
    .idle(idle_fx), .protocol_error(perr_fx)
  );

  system_bus_arbiter #(
    .NUM_MASTERS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXR), .ROUND_ROBIN(1)
  ) dut_rr (
    .clk(clk), .reset_n(rst_n), .m_bus(rr_m), .s_bus(rr_s),
    .idle(idle_rr), .protocol_error(perr_rr)
  );

  int total = 0;
  int bad   = 0;

  task automatic clr_fx();
    fx_m.read_req = '0; fx_m.write_req = '0; fx_m.addr = '0;
    fx_m.write_data = '0; fx_m.byte_enable = '0;
    fx_s.ready = 1'b1; fx_s.read_data = '0; fx_s.read_data_valid = 1'b0;
  endtask

  task automatic clr_rr();
    rr_m.read_req = '0; rr_m.write_req = '0; rr_m.addr = '0;
    rr_m.write_data = '0; rr_m.byte_enable = '0;
    rr_s.ready = 1'b1; rr_s.read_data = '0; rr_s.read_data_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_fx(); clr_rr();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fx_m.write_req = 2'b11; fx_m.read_req = 2'b10;
    rr_m.read_req = 3'b111; rr_m.write_req = 3'b010;
    rr_s.read_data_valid = 1'b1;
    #1;
    total++;
    if ({fx_m.ready, fx_s.read_req, fx_s.write_req} !== 4'b0) begin
      bad++; $display("FAIL reset_mask_fx got=%b exp=0000", {fx_m.ready, fx_s.read_req, fx_s.write_req});
    end
    total++;
    if ({rr_m.ready, rr_s.read_req, rr_s.write_req, rr_m.read_data_valid} !== 8'b0) begin
      bad++; $display("FAIL reset_mask_rr got=%b exp=00000000",
                      {rr_m.ready, rr_s.read_req, rr_s.write_req, rr_m.read_data_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clr_fx(); clr_rr();
    #1;
    total++;
    if ({idle_fx, perr_fx, idle_rr, perr_rr} !== 4'b1010) begin
      bad++; $display("FAIL reset_state got=%b exp=1010", {idle_fx, perr_fx, idle_rr, perr_rr});
    end
  endtask

  task automatic test_fixed_priority();
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    logic [BW-1:0] b0, b1;
    logic [1:0]    exp_rdy;
    logic [AW-1:0] exp_a;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      a0 = AW'($urandom); a1 = AW'($urandom); d0 = $urandom; d1 = $urandom;
      b0 = BW'($urandom); b1 = BW'($urandom);
      fx_m.addr = {a1, a0}; fx_m.write_data = {d1, d0}; fx_m.byte_enable = {b1, b0};
      fx_m.write_req = (c == 6) ? 2'b10 : 2'b11;
      fx_m.read_req  = (c == 8) ? 2'b01 : 2'b00;
      fx_s.ready     = (c != 7);
      exp_rdy = (c == 7) ? 2'b00 : ((c == 6) ? 2'b10 : 2'b01);
      exp_a   = (c == 6) ? a1 : a0;
      #1;
      total++;
      if ({fx_m.ready, fx_s.write_req, fx_s.read_req} !== {exp_rdy, 1'b1, 1'b0}) begin
        bad++; $display("FAIL fixed_grant c=%0d got=%b exp=%b", c,
                        {fx_m.ready, fx_s.write_req, fx_s.read_req}, {exp_rdy, 1'b1, 1'b0});
      end
      total++;
      if (fx_s.addr !== exp_a || fx_s.write_data !== ((c == 6) ? d1 : d0)
          || fx_s.byte_enable !== ((c == 6) ? b1 : b0)) begin
        bad++; $display("FAIL fixed_mux c=%0d got_addr=%h exp_addr=%h", c, fx_s.addr, exp_a);
      end
    end
    @(negedge clk);
    clr_fx();
  endtask

  task automatic test_round_robin();
    int exp_order [9] = '{0, 1, 2, 0, -1, -1, 1, 2, 0};
    logic [2:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      rr_m.write_req = 3'b111;
      for (int i = 0; i < NR; i++) rr_m.addr[i*AW +: AW] = AW'(100 * i + c);
      rr_s.ready = (exp_order[c] >= 0);
      exp_rdy = (exp_order[c] >= 0) ? 3'(1 << exp_order[c]) : 3'b000;
      #1;
      total++;
      if ({rr_m.ready, rr_s.write_req} !== {exp_rdy, 1'b1}) begin
        bad++; $display("FAIL rr_order c=%0d got=%b exp=%b", c, {rr_m.ready, rr_s.write_req}, {exp_rdy, 1'b1});
      end
      if (exp_order[c] >= 0) begin
        total++;
        if (rr_s.addr !== AW'(100 * exp_order[c] + c)) begin
          bad++; $display("FAIL rr_addr c=%0d got=%h exp=%h", c, rr_s.addr, AW'(100 * exp_order[c] + c));
        end
      end
    end
    @(negedge clk);
    clr_rr();
  endtask

  task automatic test_read_blocking();
    bit         req_tab [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    bit         vld_tab [8] = '{0, 0, 0, 1, 0, 1, 1, 0};
    logic [2:0] rdy_tab [8] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000};
    bit         rrq_tab [8] = '{1, 1, 0, 0, 1, 0, 0, 0};
    bit         idl_tab [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
    logic [DW-1:0] dat;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      dat = $urandom;
      rr_m.read_req = req_tab[c] ? 3'b010 : 3'b000;
      rr_s.read_data_valid = vld_tab[c];
      rr_s.read_data = dat;
      #1;
      total++;
      if ({rr_m.ready, rr_s.read_req, rr_m.read_data_valid, idle_rr}
          !== {rdy_tab[c], rrq_tab[c], (vld_tab[c] ? 3'b010 : 3'b000), idl_tab[c]}) begin
        bad++; $display("FAIL rd_block c=%0d got=%b exp=%b", c,
                        {rr_m.ready, rr_s.read_req, rr_m.read_data_valid, idle_rr},
                        {rdy_tab[c], rrq_tab[c], (vld_tab[c] ? 3'b010 : 3'b000), idl_tab[c]});
      end
      if (vld_tab[c]) begin
        total++;
        if (rr_m.read_data !== dat) begin
          bad++; $display("FAIL rd_block_data c=%0d got=%h exp=%h", c, rr_m.read_data, dat);
        end
      end
    end
    clr_rr();
  endtask

  task automatic test_interleaved_reads();
    logic [2:0]    req_tab [6] = '{3'b001, 3'b010, 3'b001, 3'b001, 3'b000, 3'b000};
    bit            vld_tab [6] = '{0, 0, 1, 1, 1, 0};
    logic [DW-1:0] dat_tab [6] = '{32'h0, 32'h0, 32'hA, 32'hB, 32'hC, 32'h0};
    logic [2:0]    rdy_tab [6] = '{3'b001, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    logic [2:0]    rdv_tab [6] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b001, 3'b000};
    bit            idl_tab [6] = '{0, 0, 0, 0, 0, 1};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rr_m.read_req = req_tab[c];
      rr_s.read_data_valid = vld_tab[c];
      rr_s.read_data = dat_tab[c];
      #1;
      total++;
      if ({rr_m.ready, rr_m.read_data_valid, idle_rr} !== {rdy_tab[c], rdv_tab[c], idl_tab[c]}) begin
        bad++; $display("FAIL interleave c=%0d got=%b exp=%b", c,
                        {rr_m.ready, rr_m.read_data_valid, idle_rr}, {rdy_tab[c], rdv_tab[c], idl_tab[c]});
      end
      if (vld_tab[c]) begin
        total++;
        if (rr_m.read_data !== dat_tab[c]) begin
          bad++; $display("FAIL interleave_data c=%0d got=%h exp=%h", c, rr_m.read_data, dat_tab[c]);
        end
      end
    end
    clr_rr();
  endtask

  task automatic test_spurious();
    do_reset();
    @(negedge clk);
    rr_s.read_data_valid = 1'b1;
    #1;
    total++;
    if ({rr_m.read_data_valid, perr_rr} !== 4'b0000) begin
      bad++; $display("FAIL spurious_rdv got=%b exp=0000", {rr_m.read_data_valid, perr_rr});
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rr_s.read_data_valid = 1'b0;
      #1;
      total++;
      if (perr_rr !== 1'b1) begin
        bad++; $display("FAIL spurious_sticky c=%0d got=%b exp=1", c, perr_rr);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (perr_rr !== 1'b0) begin
      bad++; $display("FAIL spurious_clear got=%b exp=0", perr_rr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      rr_m.read_req = 3'b100;
      #1;
      total++;
      if (rr_m.ready !== 3'b100) begin
        bad++; $display("FAIL mid_setup c=%0d got=%b exp=100", c, rr_m.ready);
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    rr_m.read_req = 3'b111; rr_m.write_req = 3'b111;
    rr_s.read_data_valid = 1'b1;
    #1;
    total++;
    if ({rr_m.ready, rr_s.read_req, rr_s.write_req, rr_m.read_data_valid} !== 8'b0) begin
      bad++; $display("FAIL mid_mask got=%b exp=00000000",
                      {rr_m.ready, rr_s.read_req, rr_s.write_req, rr_m.read_data_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_m.read_req = 3'b000; rr_m.write_req = 3'b111;
    rr_s.read_data_valid = 1'b0;
    #1;
    total++;
    if (rr_m.ready !== 3'b001) begin
      bad++; $display("FAIL mid_first_accept got=%b exp=001", rr_m.ready);
    end
    @(negedge clk);
    rr_m.write_req = 3'b000;
    #1;
    total++;
    if (idle_rr !== 1'b1) begin
      bad++; $display("FAIL mid_count_cleared got=%b exp=1", idle_rr);
    end
    @(negedge clk);
    rr_s.read_data_valid = 1'b1;
    #1;
    total++;
    if (rr_m.read_data_valid !== 3'b000) begin
      bad++; $display("FAIL mid_stale_rdv got=%b exp=000", rr_m.read_data_valid);
    end
    @(negedge clk);
    rr_s.read_data_valid = 1'b0;
    #1;
    total++;
    if (perr_rr !== 1'b1) begin
      bad++; $display("FAIL mid_stale_perr got=%b exp=1", perr_rr);
    end
  endtask

  // Reference model: pending request per master, queue of issuing IDs, next-priority index.
  task automatic test_random();
    bit            pend [NR];
    int            kind [NR];
    logic [AW-1:0] ra [NR];
    logic [DW-1:0] rd [NR];
    logic [BW-1:0] rb [NR];
    int            q [$];
    int            ptr, g, idx;
    bit            wr, full, acc, rdy, vld, any;
    logic [2:0]    exp_rdy, exp_rdv;
    logic [DW-1:0] dat;
    do_reset();
    ptr = 0;
    for (int i = 0; i < NR; i++) pend[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1;
          kind[i] = $urandom_range(0, 5) == 0 ? 2 : $urandom_range(0, 1);
          ra[i] = AW'($urandom); rd[i] = $urandom; rb[i] = BW'($urandom);
        end
        rr_m.read_req[i]  = pend[i] && (kind[i] != 1);
        rr_m.write_req[i] = pend[i] && (kind[i] != 0);
        rr_m.addr[i*AW +: AW] = ra[i];
        rr_m.write_data[i*DW +: DW] = rd[i];
        rr_m.byte_enable[i*BW +: BW] = rb[i];
      end
      rdy = ($urandom_range(0, 3) != 0);
      vld = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      dat = $urandom;
      rr_s.ready = rdy;
      rr_s.read_data_valid = vld;
      rr_s.read_data = dat;

      g = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (ptr + k) % NR;
        if (g < 0 && pend[idx]) g = idx;
      end
      any = (g >= 0);
      wr = any && (kind[g] != 0);
      full = (q.size() >= MAXR);
      acc = any && rdy && (wr || !full);
      exp_rdy = acc ? 3'(1 << g) : 3'b000;
      exp_rdv = vld ? 3'(1 << q[0]) : 3'b000;
      #1;
      total++;
      if ({rr_m.ready, rr_s.read_req, rr_s.write_req} !== {exp_rdy, any && !wr && !full, wr}) begin
        bad++; $display("FAIL rand_grant c=%0d got=%b exp=%b", c,
                        {rr_m.ready, rr_s.read_req, rr_s.write_req}, {exp_rdy, any && !wr && !full, wr});
      end
      total++;
      if ({rr_s.addr, rr_s.write_data, rr_s.byte_enable}
          !== (any ? {ra[g], rd[g], rb[g]} : {AW'(0), DW'(0), BW'(0)})) begin
        bad++; $display("FAIL rand_mux c=%0d got_addr=%h exp_grant=%0d", c, rr_s.addr, g);
      end
      total++;
      if ({rr_m.read_data_valid, rr_m.read_data} !== {exp_rdv, dat}) begin
        bad++; $display("FAIL rand_return c=%0d got=%b exp=%b", c, rr_m.read_data_valid, exp_rdv);
      end
      total++;
      if ({idle_rr, perr_rr} !== {(q.size() == 0) && !(pend[0] || pend[1] || pend[2]), 1'b0}) begin
        bad++; $display("FAIL rand_idle c=%0d got=%b", c, {idle_rr, perr_rr});
      end

      if (vld) void'(q.pop_front());
      if (acc) begin
        if (!wr) q.push_back(g);
        ptr = (g + 1) % NR;
        pend[g] = 0;
      end
    end
    @(negedge clk);
    clr_rr();
  endtask

  initial begin
    clr_fx();
    clr_rr();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_read_blocking();
    test_interleaved_reads();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
